// File: rtl/nrs_pilot_gen.sv
// rtl/nrs_pilot_gen.sv - NB-IoT NRS pilot generator: Gold sequence to QPSK sign bits for the 4-entry pilot buffer
module nrs_pilot_gen #(
    parameter int NC         = 1600,
    parameter int NRB_MAX_DL = 110,
    parameter int SYM0       = 5,
    parameter int SYM1       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] ncell_id,
    input  logic [4:0] ns,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       wr_en,
    output logic [1:0] wr_addr,
    output logic       nrs_r,
    output logic       nrs_i
);

    localparam logic [10:0] WARM_LAST = 11'(NC - 1);
    localparam logic [10:0] SKIP_LAST = 11'(2 * (NRB_MAX_DL - 1) - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WARMUP, SKIP, EMIT, DONE} state_t;

    state_t      state, state_d;
    logic [10:0] cnt, cnt_d;
    logic        sym, sym_d;
    logic        hold, hold_d;
    logic [8:0]  id_q, id_d;
    logic [4:0]  ns_q, ns_d;
    logic [30:0] x1, x1_d, x2, x2_d;
    logic        busy_d, done_d, err_d, wr_en_d, nrs_r_d, nrs_i_d;
    logic [1:0]  wr_addr_d;
    logic [2:0]  l_cur;
    logic [30:0] c_mul_a, c_mul_b, c_init;
    logic        c_bit;

    assign c_bit = x1[0] ^ x2[0];
    assign l_cur = sym ? 3'(SYM1) : 3'(SYM0);

    // Largest product is 147*1007*1024, well inside 31 bits.
    always_comb begin
        c_mul_a = 31'd7 * (31'(ns_q) + 31'd1) + 31'(l_cur) + 31'd1;
        c_mul_b = {21'd0, id_q, 1'b1};
        c_init  = ((c_mul_a * c_mul_b) << 10) + c_mul_b;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt + 11'd1;
        sym_d     = sym;
        hold_d    = hold;
        id_d      = id_q;
        ns_d      = ns_q;
        x1_d      = x1;
        x2_d      = x2;
        err_d     = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        nrs_r_d   = nrs_r;
        nrs_i_d   = nrs_i;
        if (state == WARMUP || state == SKIP || state == EMIT) begin
            x1_d = {x1[3] ^ x1[0], x1[30:1]};
            x2_d = {x2[3] ^ x2[2] ^ x2[1] ^ x2[0], x2[30:1]};
        end
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    if (ncell_id <= 9'd503 && ns <= 5'd19) begin
                        id_d    = ncell_id;
                        ns_d    = ns;
                        sym_d   = 1'b0;
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                x1_d    = 31'd1;
                x2_d    = c_init;
                cnt_d   = '0;
                state_d = WARMUP;
            end
            WARMUP: begin
                if (cnt == WARM_LAST) begin
                    cnt_d   = '0;
                    state_d = SKIP;
                end
            end
            SKIP: begin
                if (cnt == SKIP_LAST) begin
                    cnt_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                // Even cycles park c(2m+218) so odd cycles can write the full QPSK pair.
                if (!cnt[0]) begin
                    hold_d = c_bit;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {sym, cnt[1]};
                    nrs_r_d   = hold;
                    nrs_i_d   = c_bit;
                end
                if (cnt[1:0] == 2'd3) begin
                    cnt_d = '0;
                    if (sym) begin
                        state_d = DONE;
                    end else begin
                        sym_d   = 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == LOAD) || (state_d == WARMUP) || (state_d == SKIP) || (state_d == EMIT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            sym     <= 1'b0;
            hold    <= 1'b0;
            id_q    <= '0;
            ns_q    <= '0;
            x1      <= '0;
            x2      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            nrs_r   <= 1'b0;
            nrs_i   <= 1'b0;
        end else begin
            cnt     <= cnt_d;
            sym     <= sym_d;
            hold    <= hold_d;
            id_q    <= id_d;
            ns_q    <= ns_d;
            x1      <= x1_d;
            x2      <= x2_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
            wr_en   <= wr_en_d;
            wr_addr <= wr_addr_d;
            nrs_r   <= nrs_r_d;
            nrs_i   <= nrs_i_d;
        end
    end

endmodule

// File: tb/tb_nrs_pilot_gen.sv
// tb/tb_nrs_pilot_gen.sv - self-checking bench for nrs_pilot_gen against a Gold-sequence reference model
module tb_nrs_pilot_gen;

    localparam int NC      = 1600;
    localparam int SKIPN   = 218;
    localparam int DONE_AT = 3647;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [8:0] ncell_id;
    logic [4:0] ns;
    logic       busy, done, err, wr_en, nrs_r, nrs_i;
    logic [1:0] wr_addr;

    int vectors     = 0;
    int miscompares = 0;

    nrs_pilot_gen dut (
        .clk(clk), .rst(rst), .start(start), .ncell_id(ncell_id), .ns(ns),
        .busy(busy), .done(done), .err(err), .wr_en(wr_en), .wr_addr(wr_addr),
        .nrs_r(nrs_r), .nrs_i(nrs_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] id;
        logic [4:0] nsv;
        bit         bad;
        bit         hammer;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint cinit_of(input int id, input int nsv, input int l);
        return 64'(1024 * (7 * (nsv + 1) + l + 1) * (2 * id + 1) + 2 * id + 1);
    endfunction

    // c(n) = x1(n+Nc) xor x2(n+Nc); returns c(218)..c(221) in bits 0..3.
    function automatic bit [3:0] gold4(input longint cinit);
        bit       x1s[NC + SKIPN + 4];
        bit       x2s[NC + SKIPN + 4];
        bit [3:0] g;
        for (int n = 0; n < 31; n++) begin
            x1s[n] = (n == 0);
            x2s[n] = cinit[n];
        end
        for (int n = 0; n + 31 < NC + SKIPN + 4; n++) begin
            x1s[n + 31] = x1s[n + 3] ^ x1s[n];
            x2s[n + 31] = x2s[n + 3] ^ x2s[n + 2] ^ x2s[n + 1] ^ x2s[n];
        end
        for (int j = 0; j < 4; j++) g[j] = x1s[NC + SKIPN + j] ^ x2s[NC + SKIPN + j];
        return g;
    endfunction

    task automatic run_slot(input logic [8:0] id, input logic [4:0] nsv, input bit hammer);
        bit [3:0] g[2];
        int       waddr[4];
        bit       wr[4];
        bit       wi[4];
        int       nwr = 0, done_cyc = -1, busy_bad = 0, nerr = 0;
        logic     busy_at_done = 1'bx;
        g[0] = gold4(cinit_of(id, nsv, 5));
        g[1] = gold4(cinit_of(id, nsv, 6));
        ncell_id = id;
        ns       = nsv;
        start    = 1'b1;
        for (int k = 1; k <= DONE_AT + 200 && done_cyc < 0; k++) begin
            @(negedge clk);
            start = hammer;
            if (hammer) begin
                ncell_id = 9'($urandom);
                ns       = 5'($urandom);
            end
            if (wr_en === 1'b1) begin
                if (nwr < 4) begin
                    waddr[nwr] = int'(wr_addr);
                    wr[nwr]    = nrs_r;
                    wi[nwr]    = nrs_i;
                end
                nwr++;
            end
            if (err !== 1'b0) nerr++;
            if (done === 1'b1) begin
                done_cyc     = k;
                busy_at_done = busy;
            end else if (busy !== 1'b1) begin
                busy_bad++;
            end
        end
        start = 1'b0;
        check("done_cycle", done_cyc, DONE_AT);
        check("busy_during_slot", busy_bad, 0);
        check("busy_at_done", 32'(busy_at_done), 0);
        check("write_count", nwr, 4);
        check("err_during_slot", nerr, 0);
        for (int j = 0; j < 4 && j < nwr; j++) begin
            check($sformatf("wr_addr[%0d]", j), waddr[j], j);
            check($sformatf("nrs_r[%0d]", j), 32'(wr[j]), 32'(g[j / 2][2 * (j % 2)]));
            check($sformatf("nrs_i[%0d]", j), 32'(wi[j]), 32'(g[j / 2][2 * (j % 2) + 1]));
        end
        @(negedge clk);
        check("post_done_quiet", {done, wr_en, busy}, 0);
    endtask

    task automatic run_err(input logic [8:0] id, input logic [4:0] nsv);
        int nwr = 0, nbusy = 0;
        ncell_id = id;
        ns       = nsv;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", 32'(err), 1);
        check("err_busy", 32'(busy), 0);
        @(negedge clk);
        check("err_width", 32'(err), 0);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (wr_en !== 1'b0) nwr++;
            if (busy !== 1'b0) nbusy++;
        end
        check("err_writes", nwr, 0);
        check("err_busy_after", nbusy, 0);
    endtask

    initial begin
        vec_t tbl[10];
        int   nwr, nbusy;
        tbl[0] = '{9'd0,   5'd0,  1'b0, 1'b0};
        tbl[1] = '{9'd503, 5'd19, 1'b0, 1'b0};
        tbl[2] = '{9'd504, 5'd0,  1'b1, 1'b0};
        tbl[3] = '{9'd0,   5'd20, 1'b1, 1'b0};
        tbl[4] = '{9'd511, 5'd31, 1'b1, 1'b0};
        tbl[5] = '{9'd17,  5'd3,  1'b0, 1'b1};
        for (int i = 6; i < 9; i++)
            tbl[i] = '{9'($urandom_range(503, 0)), 5'($urandom_range(19, 0)), 1'b0, 1'b0};
        tbl[9] = '{9'($urandom_range(511, 504)), 5'($urandom_range(19, 0)), 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; ncell_id = '0; ns = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, err, wr_en, wr_addr, nrs_r, nrs_i}, 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].bad) run_err(tbl[i].id, tbl[i].nsv);
            else            run_slot(tbl[i].id, tbl[i].nsv, tbl[i].hammer);
        end

        // Back-to-back slots: second start lands on the cycle after done.
        run_slot(9'd0, 5'd0, 1'b0);
        run_slot(9'd0, 5'd1, 1'b0);

        // Reset in the middle of SKIP for symbol 5.
        ncell_id = 9'd42; ns = 5'd7; start = 1'b1;
        nwr = 0;
        for (int k = 1; k <= 1700; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (wr_en !== 1'b0) nwr++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_outputs", {busy, done, err, wr_en, wr_addr, nrs_r, nrs_i}, 0);
        nbusy = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (wr_en !== 1'b0) nwr++;
            if (busy !== 1'b0) nbusy++;
        end
        check("midreset_writes", nwr, 0);
        check("midreset_idle", nbusy, 0);
        run_slot(9'd42, 5'd7, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nrs_pilot_gen.md
Name: nrs_pilot_gen

Overview:
- Transmit-side producer of the NB-IoT narrowband reference signal (NRS) pilots consumed by the channel-estimation complex multiplier.
- Per slot, generates the LTE Gold sequence c(n) for NRS OFDM symbols l=5 and l=6.
- Maps the c(n) bits to QPSK sign bits (nrs_r, nrs_i), two pilots per symbol.
- Writes them into the 4-entry pilot buffer that feeds the multiplier's pilot inputs, then signals done.

Parameters:
- NC, 1600: Gold sequence warm-up length (Nc).
- NRB_MAX_DL, 110: N_RB^max,DL; pilot index m' = m + NRB_MAX_DL - 1.
- SYM0, 5: first NRS symbol index in slot.
- SYM1, 6: second NRS symbol index in slot.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to generate a slot's pilots; sampled only in IDLE.
- ncell_id  in  9  NB-IoT cell ID, 0..503; sampled with start.
- ns  in  5  slot number, 0..19; sampled with start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse when all 4 pilots are written.
- err  out  1  one-cycle pulse when start carries ncell_id>503 or ns>19.
- wr_en  out  1  pilot buffer write strobe.
- wr_addr  out  2  pilot buffer address.
- nrs_r  out  1  real sign bit: 0 → +1/√2, 1 → -1/√2.
- nrs_i  out  1  imaginary sign bit, same encoding.

Behaviour:
- **Reset.**
  - rst sampled high forces state IDLE.
  - busy, done, err, wr_en, wr_addr, nrs_r, nrs_i all =0; LFSRs =0.
  - Reset mid-operation aborts with no further writes; already-written buffer entries are not cleared.
- **Start acceptance.**
  - In IDLE with start=1 and valid params: latch ncell_id and ns, set l=SYM0, go to LOAD.
  - Invalid params: err=1 for one cycle, stay IDLE, no writes.
  - start outside IDLE is ignored.
- **FSM.** IDLE → LOAD → WARMUP → SKIP → EMIT, then either LOAD (next symbol) or DONE → IDLE.
- **LOAD (1 cycle).**
  - c_init = 2^10·(7·(ns+1)+l+1)·(2·ncell_id+1) + 2·ncell_id + 1.
  - Max value < 2^29; computed in 31-bit unsigned, no truncation.
  - Load x1 = 31'd1 and x2 = c_init.
- **LFSR update, every cycle in WARMUP/SKIP/EMIT.**
  - x1 shifts right; new MSB = x1[3]^x1[0].
  - x2 shifts right; new MSB = x2[3]^x2[2]^x2[1]^x2[0].
  - Current bit c = x1[0]^x2[0], taken before the shift.
- **WARMUP.** Exactly NC cycles, counted with an 11-bit counter.
- **SKIP.** Exactly 2·(NRB_MAX_DL-1) = 218 cycles, discarding c(0..217).
- **EMIT (4 cycles), bits c(218)..c(221).**
  - Cycles 1 and 3: capture c into a hold register.
  - Cycle 2: wr_en=1, nrs_r=hold=c(218), nrs_i=c(219).
  - Cycle 4: wr_en=1, nrs_r=c(220), nrs_i=c(221).
  - Outputs are registered, so the writes appear on the edge after cycles 2 and 4.
- **Buffer addresses.**
  - Symbol l=SYM0 writes addr 0 (m=0) then 1 (m=1).
  - Symbol l=SYM1 writes addr 2 then 3.
  - wr_en is never high in any other state.
- **Symbol sequencing.**
  - After EMIT with l=SYM0: l=SYM1, go to LOAD.
  - After EMIT with l=SYM1: go to DONE.
- **DONE.** done=1 for one cycle, busy drops in the same cycle, then IDLE.
- **Timing.**
  - 1823 cycles per symbol (LOAD 1 + NC + 218 + 4).
  - done is high exactly 3647 cycles after the edge that accepted start.
  - New start is accepted on the cycle after done.
- **Counters.** Saturate-free; each reloads to 0 on state entry. No wrap-around is ever observed.

Test Plan:
- Reset then ncell_id=0, ns=0 start pulse → c_init(l=5)=13313, c_init(l=6)=14337 (checked via golden model); exactly 4 writes at addrs 0,1,2,3; nrs_r/nrs_i match a reference Gold generator; done at cycle 3647; busy high cycles 1..3646.
- ncell_id=503, ns=19 (max c_init=147·1007·1024+1007) → no overflow, pilot bits match model, identical timing.
- ncell_id=504 or ns=20 with start → err pulse 1 cycle after start, busy=0, zero writes; a following valid start works normally.
- start re-asserted every cycle while busy → ignored; exactly one done and 4 writes per accepted start.
- rst asserted during SKIP of symbol l=5 → next cycle all outputs 0, IDLE; no writes; new start completes in 3647 cycles.
- Back-to-back start on the cycle after done, ns=0 then ns=1 → 8 writes total, second slot bits differ per model.
